dsp_mul_unsigned_reg: RTL and testbench
=======================================

DSP_MUL_UNSIGNED_REG -- requirements
Module: dsp_mul_unsigned_reg

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all sequential logic SHALL update on the falling edge only.
REQ-003 reset  input  1  asynchronous, active-low reset: 0 = in reset, 1 = normal operation.
REQ-004 A  input  20  unsigned multiplicand, range 0..1048575.
REQ-005 B  input  18  unsigned multiplier, range 0..262143.
REQ-006 P  output  38  unsigned registered product.
REQ-007 Port order SHALL be clk, reset, A, B, P, so that a positional instantiation binds correctly.

Function
REQ-008 Stage 1: the block SHALL capture A and B into internal registers A_r (20 bits) and B_r (18 bits) on every falling clk edge while reset=1.
REQ-009 Stage 2: the block SHALL load P with the full product A_r*B_r on every falling clk edge while reset=1.
REQ-010 The multiplication SHALL be unsigned, full precision and 38 bits wide, with no truncation, saturation, rounding or sign extension.
REQ-011 The largest result, 1048575*262143 = 274876596225, SHALL be represented exactly.
REQ-012 Latency: operands present at falling edge N SHALL appear on P immediately after falling edge N+1.
REQ-013 Throughput SHALL be one new operand pair per clock; back-to-back operands SHALL yield back-to-back results in the same order.
REQ-014 No rising-edge-sensitive storage SHALL exist; A and B changing only around rising edges SHALL be captured at the next falling edge.
REQ-015 P SHALL be driven only from a register, with no combinational path from A or B to P.
REQ-016 The product SHALL be formed combinationally between the two register stages, either with the behavioral operator or as a partial-product array; the result SHALL be bit-identical either way.
REQ-017 There SHALL be no valid or enable handshake; P is meaningful two falling edges after operands are applied following reset release.

Reset
REQ-018 While reset=0, A_r, B_r and P SHALL be forced to 0 asynchronously, immediately and independent of clk.
REQ-019 P SHALL stay at 0 for as long as reset=0, whatever the values of A and B.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight operands; nothing captured before reset may appear on P afterwards.
REQ-021 After reset goes from 0 to 1:
- the first capture SHALL occur at the next falling edge;
- P SHALL hold 0 until that captured product is loaded on the following falling edge.
REQ-022 Reset release SHALL not cause a glitch or spurious nonzero value on P.

Verification
REQ-023 Reset: hold reset=0 for two clocks with A=7, B=3 -> P=0 throughout, including between clock edges.
REQ-024 Directed: reset=1, apply A=5, B=2 at a falling edge -> P=10 after exactly two falling edges, and P is not yet 10 after one.
REQ-025 Extremes, each checked two falling edges after application:
- A=1048575, B=262143 -> P=274876596225;
- A=0, B=262143 -> P=0;
- A=1, B=1 -> P=1.
REQ-026 Pipeline: apply (3,4), (10,20), (1048575,1) on consecutive falling edges -> P = 12, 200, 1048575 on consecutive falling edges, starting at the second edge.
REQ-027 Random: 32 random unsigned A,B pairs, each held two falling edges -> P equals the 38-bit reference product A*B every time.
REQ-028 Mid-operation reset: apply A=100, B=100, then pull reset=0 before the second falling edge -> P=0 at once, and 10000 never appears on P after reset is released.

Source files
------------

// File: rtl/dsp_mul_unsigned_reg.sv
// Two-stage unsigned 20x18 multiplier clocked on the falling edge of clk.
// Stage p0 registers the operands, stage p1 registers the full 38-bit
// product. The product is formed as a shift-and-add partial-product array,
// which is bit-identical to the behavioral unsigned '*' at this width.
module dsp_mul_unsigned_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] A,
  input  logic [17:0] B,
  output logic [37:0] P
);

  localparam int A_W = 20;
  localparam int B_W = 18;
  localparam int P_W = A_W + B_W;

  logic [A_W-1:0] r_a_p0;
  logic [B_W-1:0] r_b_p0;
  logic [P_W-1:0] w_prod;
  logic [P_W-1:0] r_p_p1;

  // Unsigned partial-product sum: one shifted copy of a per set bit of b.
  // The accumulator is sized to the full product so nothing is truncated.
  function automatic logic [P_W-1:0] full_product(
    input logic [A_W-1:0] a,
    input logic [B_W-1:0] b
  );
    logic [P_W-1:0] acc;
    logic [P_W-1:0] a_ext;
    acc   = '0;
    a_ext = {{B_W{1'b0}}, a};
    for (int i = 0; i < B_W; i++) begin
      if (b[i]) begin
        acc = acc + (a_ext << i);
      end
    end
    return acc;
  endfunction

  // ---- stage p0: operand capture on the falling edge ----
  // Operands are cleared by reset so nothing in flight survives it.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_a_p0 <= '0;
      r_b_p0 <= '0;
    end else begin
      r_a_p0 <= A;
      r_b_p0 <= B;
    end
  end

  // ---- combinational product between the register stages ----
  always_comb begin
    w_prod = full_product(r_a_p0, r_b_p0);
  end

  // ---- stage p1: product register, the only driver of P ----
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_p_p1 <= '0;
    end else begin
      r_p_p1 <= w_prod;
    end
  end

  assign P = r_p_p1;

endmodule

// File: tb/tb_dsp_mul_unsigned_reg.sv
// Bench for dsp_mul_unsigned_reg. Stimulus is driven just after rising edges;
// each expected product is queued with the falling-edge count at which it
// must be on P, and a monitor compares it half a period later.
module tb_dsp_mul_unsigned_reg;

  logic        clk;
  logic        reset;
  logic [19:0] A;
  logic [17:0] B;
  logic [37:0] P;

  typedef struct {
    int          due;
    logic [37:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   edge_cnt  = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;

  dsp_mul_unsigned_reg dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .P     (P)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  always @(negedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: P=%0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int due, input logic [37:0] val, input string name);
    exp_t e;
    e.due  = due;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  // Drive a pair just after a rising edge and hold it for 'hold' clocks.
  // Captured at falling edge edge_cnt+1, visible on P from edge_cnt+2.
  task automatic drive(input logic [19:0] a, input logic [17:0] b,
                       input logic [37:0] exp, input int hold, input string name);
    @(posedge clk);
    A = a;
    B = b;
    for (int k = 0; k < hold; k++) push(edge_cnt + 2 + k, exp, name);
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: %0d expected results never compared, expected 0 pending", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: half a period after each falling edge, compare the due entry.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        if (q[0].due < edge_cnt) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s: result for edge %0d missed, expected %0d", q[0].name, q[0].due, q[0].val);
          void'(q.pop_front());
        end else if (q[0].due == edge_cnt) begin
          check(q[0].name, P, q[0].val);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [19:0] ra;
    logic [17:0] rb;
    logic [63:0] ref_p;

    // Reset held with nonzero operands: P stays 0 on and between edges.
    reset = 1'b0;
    A = 20'd7;
    B = 18'd3;
    #1 check("reset_t1", P, 38'd0);
    @(negedge clk); #1 check("reset_neg1", P, 38'd0);
    @(posedge clk); #2 check("reset_pos1", P, 38'd0);
    @(negedge clk); #1 check("reset_neg2", P, 38'd0);
    @(posedge clk); #2 check("reset_pos2", P, 38'd0);

    // Release together with A=5,B=2: 0 after one edge, 10 after two.
    @(posedge clk);
    reset = 1'b1;
    A = 20'd5;
    B = 18'd2;
    push(edge_cnt + 1, 38'd0, "directed_edge1");
    push(edge_cnt + 2, 38'd10, "directed_edge2");
    #1 check("release_noglitch", P, 38'd0);
    @(posedge clk);
    drain("directed");

    // Extremes, each held two falling edges.
    drive(20'd1048575, 18'd262143, 38'd274876596225, 2, "max_x_max");
    drive(20'd0,       18'd262143, 38'd0,            2, "zero_x_max");
    drive(20'd1,       18'd1,      38'd1,            2, "one_x_one");
    drive(20'd1048575, 18'd0,      38'd0,            2, "max_x_zero");

    // Back-to-back pipeline.
    drive(20'd3,       18'd4,  38'd12,      1, "pipe0");
    drive(20'd10,      18'd20, 38'd200,     1, "pipe1");
    drive(20'd1048575, 18'd1,  38'd1048575, 1, "pipe2");
    drive(20'd1,       18'd262143, 38'd262143, 1, "pipe3");
    drain("pipeline");

    // Random pairs, each held two falling edges.
    for (int i = 0; i < 32; i++) begin
      ra = 20'($urandom_range(0, 1048575));
      rb = 18'($urandom_range(0, 262143));
      ref_p = 64'(ra) * 64'(rb);
      drive(ra, rb, ref_p[37:0], 2, $sformatf("rand%0d", i));
    end
    drain("random");

    // Mid-operation reset: 100*100 is captured, then reset before P loads it.
    @(posedge clk);
    A = 20'd100;
    B = 18'd100;
    @(posedge clk);
    reset = 1'b0;
    #1 check("midreset_immediate", P, 38'd0);
    A = 20'd0;
    B = 18'd0;
    @(negedge clk); #1 check("midreset_held", P, 38'd0);
    @(posedge clk);
    reset = 1'b1;
    #1 check("midreset_release", P, 38'd0);
    for (int k = 1; k <= 4; k++) push(edge_cnt + k, 38'd0, $sformatf("midreset_after%0d", k));
    @(posedge clk);
    drain("midreset");

    // Normal operation resumes after the mid-operation reset.
    drive(20'd123, 18'd456, 38'd56088, 2, "post_reset");
    drain("post_reset");

    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
